rom_read_arbiter: RTL and testbench

Two-port round-robin read arbiter that shares one synchronous single-port ROM (1-cycle registered read) between two requesters. It accepts at most one read per cycle with a valid/ack handshake and drives the ROM address. It tracks which port owns each in-flight read and returns the data to that port with a one-cycle valid pulse. It sits between the ROM and its two consumers, for example a display-pattern fetcher and a lookup unit.

---
 rtl/rom_read_arbiter.sv | 136 +++++++++++++
 tb/tb_rom_read_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter
//
// Lets two requesters share one synchronous single-port ROM that has a
// 1-cycle registered read. At most one read is accepted per cycle. When both
// ports request in the same cycle, a round-robin pointer decides the winner.
// Each accepted read carries a port tag through a two-stage pipeline. That
// pipeline lines up with the ROM's read latency, so the returned word goes back
// to the port that issued the read, as a one-cycle rvalid pulse.
//
// Ports
//   clk               single clock, all state changes on the rising edge
//   reset             synchronous active-high reset
//   req0/req1         read request, held with its address until acked
//   addr0/addr1       read address (AW bits)
//   ack0/ack1         combinational, request accepted this cycle
//   rvalid0/rvalid1   registered one-cycle pulse, rdataN is valid
//   rdata0/rdata1     read data, holds its last value between pulses
//   rom_add           registered address driven to the ROM
//   rom_data          ROM data output (registered inside the ROM)
module rom_read_arbiter #(
    parameter int AW = 12,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    output logic          ack0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    output logic          ack1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] rom_add,
    input  logic [DW-1:0] rom_data
);

    // last_reg holds the port that won the most recent transfer. Its reset
    // value is 1, so port 0 wins the first conflict after reset.
    logic          last_reg;
    logic          last_next;
    logic [AW-1:0] rom_add_reg;
    logic [AW-1:0] rom_add_next;
    logic          s1_v_reg;
    logic          s1_v_next;
    logic          s1_id_reg;
    logic          s1_id_next;
    logic          s2_v_reg;
    logic          s2_id_reg;

    logic          xfer;
    logic          win_id;

    // Grant logic depends only on the requests and the pointer. rom_data has
    // no path into the acks.
    always_comb begin
        ack0 = 1'b0;
        ack1 = 1'b0;
        if (!reset) begin
            ack0 = req0 & (~req1 | last_reg);
            ack1 = req1 & (~req0 | ~last_reg);
        end
    end

    assign xfer   = ack0 | ack1;
    assign win_id = ack1;

    always_comb begin
        last_next    = last_reg;
        rom_add_next = rom_add_reg;
        s1_v_next    = 1'b0;
        s1_id_next   = s1_id_reg;
        if (xfer) begin
            last_next    = win_id;
            rom_add_next = win_id ? addr1 : addr0;
            s1_v_next    = 1'b1;
            s1_id_next   = win_id;
        end
    end

    // Issue stage (rom_add, s1) and wait stage (s2). The ROM registers its
    // data during the wait stage, so s2 and rom_data line up.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_reg    <= 1'b1;
            rom_add_reg <= '0;
            s1_v_reg    <= 1'b0;
            s1_id_reg   <= 1'b0;
            s2_v_reg    <= 1'b0;
            s2_id_reg   <= 1'b0;
        end else begin
            last_reg    <= last_next;
            rom_add_reg <= rom_add_next;
            s1_v_reg    <= s1_v_next;
            s1_id_reg   <= s1_id_next;
            s2_v_reg    <= s1_v_reg;
            s2_id_reg   <= s1_id_reg;
        end
    end

    assign rom_add = rom_add_reg;

    // Return stage, one copy per port. Only the port named by the s2 tag
    // captures rom_data. Its pulse lasts exactly one cycle because the pulse
    // is recomputed on every edge.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_port
            localparam logic PORT_ID = 1'(gi);
            logic          rvalid_reg;
            logic          rvalid_next;
            logic [DW-1:0] rdata_reg;

            assign rvalid_next = s2_v_reg & (s2_id_reg == PORT_ID);

            always_ff @(posedge clk) begin
                if (reset) begin
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= rvalid_next;
                    if (rvalid_next) begin
                        rdata_reg <= rom_data;
                    end
                end
            end
        end
    endgenerate

    assign rvalid0 = gen_port[0].rvalid_reg;
    assign rdata0  = gen_port[0].rdata_reg;
    assign rvalid1 = gen_port[1].rvalid_reg;
    assign rdata1  = gen_port[1].rdata_reg;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed testbench for rom_read_arbiter. The bench ROM holds
// rom[a] = a[7:0] ^ 8'hA5 and has a 1-cycle registered read.
module tb_rom_read_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic          ack0, ack1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] rom_add;
    logic [DW-1:0] rom_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        int            cyc;
    } ret_t;

    ret_t ret_q[$];
    int   both_seen = 0;

    rom_read_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .addr0    (addr0),
        .ack0     (ack0),
        .rvalid0  (rvalid0),
        .rdata0   (rdata0),
        .req1     (req1),
        .addr1    (addr1),
        .ack1     (ack1),
        .rvalid1  (rvalid1),
        .rdata1   (rdata1),
        .rom_add  (rom_add),
        .rom_data (rom_data)
    );

    always #5 clk = ~clk;

    // Bench ROM: 1-cycle registered read
    always @(posedge clk) begin
        rom_data <= rom_add[7:0] ^ 8'hA5;
        cyc      <= cyc + 1;
    end

    // Return monitor: samples the registered outputs on the falling edge
    always @(negedge clk) begin
        if (rvalid0 && rvalid1) both_seen++;
        if (rvalid0) ret_q.push_back('{1'b0, rdata0, cyc});
        if (rvalid1) ret_q.push_back('{1'b1, rdata1, cyc});
    end

    // Drive one cycle of inputs at the falling edge. The short delay lets
    // the combinational acks settle before the caller checks them.
    task automatic drive(input logic r0, input logic [AW-1:0] a0,
                         input logic r1, input logic [AW-1:0] a1);
        @(negedge clk);
        req0  = r0;
        addr0 = a0;
        req1  = r1;
        addr1 = a1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        ret_q.delete();
        both_seen = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 12'h123;
        addr1 = 12'h456;
        #1;
        checks++;
        if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_acks ack0=%b ack1=%b expected 0 0", ack0, ack1);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rom_add !== 12'h000 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0 ||
            rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs rom_add=%h rv0=%b rv1=%b rd0=%h rd1=%h expected 000 0 0 00 00",
                     rom_add, rvalid0, rvalid1, rdata0, rdata1);
        end
        req0  = 1'b0;
        req1  = 1'b0;
        reset = 1'b0;
        ret_q.delete();
        $display("test_reset done");
    endtask

    task automatic test_single_read();
        int c0;
        apply_reset();
        drive(1'b1, 12'h010, 1'b0, '0);
        c0 = cyc;
        checks++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
            errors++;
            $display("FAIL single_ack ack0=%b ack1=%b expected 1 0", ack0, ack1);
        end
        idle(6);
        checks++;
        if (ret_q.size() != 1) begin
            errors++;
            $display("FAIL single_count got %0d returns expected 1", ret_q.size());
        end else begin
            checks++;
            if (ret_q[0].port !== 1'b0 || ret_q[0].data !== 8'hB5 || ret_q[0].cyc != c0 + 3) begin
                errors++;
                $display("FAIL single_return port=%b data=%h lat=%0d expected 0 B5 3",
                         ret_q[0].port, ret_q[0].data, ret_q[0].cyc - c0);
            end
        end
        checks++;
        if (rdata0 !== 8'hB5 || rvalid0 !== 1'b0) begin
            errors++;
            $display("FAIL single_hold rdata0=%h rvalid0=%b expected B5 0", rdata0, rvalid0);
        end
        $display("test_single_read returns=%0d", ret_q.size());
    endtask

    task automatic test_contention();
        logic          exp_ack1 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [DW-1:0] exp_data [4] = '{8'hA4, 8'hA7, 8'hA4, 8'hA7};
        int c0;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 12'h001, 1'b1, 12'h002);
            if (i == 0) c0 = cyc;
            checks++;
            if (ack0 !== ~exp_ack1[i] || ack1 !== exp_ack1[i]) begin
                errors++;
                $display("FAIL contention_ack[%0d] ack0=%b ack1=%b expected %b %b",
                         i, ack0, ack1, ~exp_ack1[i], exp_ack1[i]);
            end
        end
        idle(6);
        checks++;
        if (ret_q.size() != 4) begin
            errors++;
            $display("FAIL contention_count got %0d returns expected 4", ret_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ret_q[i].port !== exp_ack1[i] || ret_q[i].data !== exp_data[i] ||
                    ret_q[i].cyc != c0 + 3 + i) begin
                    errors++;
                    $display("FAIL contention_ret[%0d] port=%b data=%h cyc=%0d expected %b %h %0d",
                             i, ret_q[i].port, ret_q[i].data, ret_q[i].cyc,
                             exp_ack1[i], exp_data[i], c0 + 3 + i);
                end
            end
        end
        $display("test_contention returns=%0d", ret_q.size());
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs    [5] = '{12'h0FF, 12'h100, 12'h101, 12'h102, 12'h103};
        logic [DW-1:0] exp_data [5] = '{8'h5A, 8'hA5, 8'hA4, 8'hA7, 8'hA6};
        int c0;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, 1'b1, addrs[i]);
            if (i == 0) c0 = cyc;
            checks++;
            if (ack1 !== 1'b1 || ack0 !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ack[%0d] ack0=%b ack1=%b expected 0 1", i, ack0, ack1);
            end
        end
        idle(6);
        checks++;
        if (ret_q.size() != 5) begin
            errors++;
            $display("FAIL b2b_count got %0d returns expected 5", ret_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (ret_q[i].port !== 1'b1 || ret_q[i].data !== exp_data[i] ||
                    ret_q[i].cyc != c0 + 3 + i) begin
                    errors++;
                    $display("FAIL b2b_ret[%0d] port=%b data=%h cyc=%0d expected 1 %h %0d",
                             i, ret_q[i].port, ret_q[i].data, ret_q[i].cyc, exp_data[i], c0 + 3 + i);
                end
            end
        end
        $display("test_back_to_back returns=%0d", ret_q.size());
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        drive(1'b1, 12'h020, 1'b0, '0);
        drive(1'b0, '0, 1'b1, 12'h030);
        // Reset is sampled on the edge after the second acceptance
        @(negedge clk);
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (rom_add !== 12'h000 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0 ||
            rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
            errors++;
            $display("FAIL midflight_outputs rom_add=%h rv0=%b rv1=%b rd0=%h rd1=%h expected 000 0 0 00 00",
                     rom_add, rvalid0, rvalid1, rdata0, rdata1);
        end
        idle(5);
        checks++;
        if (ret_q.size() != 0) begin
            errors++;
            $display("FAIL midflight_discard got %0d returns expected 0", ret_q.size());
        end
        drive(1'b1, 12'h040, 1'b0, '0);
        checks++;
        if (ack0 !== 1'b1) begin
            errors++;
            $display("FAIL midflight_newack ack0=%b expected 1", ack0);
        end
        idle(5);
        checks++;
        if (ret_q.size() != 1 || ret_q[0].port !== 1'b0 || ret_q[0].data !== 8'hE5) begin
            errors++;
            $display("FAIL midflight_newread count=%0d expected 1 port0 data E5", ret_q.size());
        end
        $display("test_reset_midflight returns=%0d", ret_q.size());
    endtask

    task automatic test_fairness();
        apply_reset();
        // Port 1 wins alone, so the next conflict goes to port 0
        drive(1'b0, '0, 1'b1, 12'h005);
        checks++;
        if (ack1 !== 1'b1) begin
            errors++;
            $display("FAIL fair_p1_single ack1=%b expected 1", ack1);
        end
        idle(2);
        drive(1'b1, 12'h006, 1'b1, 12'h007);
        checks++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
            errors++;
            $display("FAIL fair_after_p1 ack0=%b ack1=%b expected 1 0", ack0, ack1);
        end
        drive(1'b0, '0, 1'b1, 12'h007);
        checks++;
        if (ack1 !== 1'b1) begin
            errors++;
            $display("FAIL fair_p1_drain ack1=%b expected 1", ack1);
        end
        // Port 0 wins alone, so the next conflict goes to port 1
        drive(1'b1, 12'h008, 1'b0, '0);
        checks++;
        if (ack0 !== 1'b1) begin
            errors++;
            $display("FAIL fair_p0_single ack0=%b expected 1", ack0);
        end
        idle(2);
        drive(1'b1, 12'h009, 1'b1, 12'h00A);
        checks++;
        if (ack0 !== 1'b0 || ack1 !== 1'b1) begin
            errors++;
            $display("FAIL fair_after_p0 ack0=%b ack1=%b expected 0 1", ack0, ack1);
        end
        idle(5);
        $display("test_fairness returns=%0d", ret_q.size());
    endtask

    task automatic test_boundary();
        apply_reset();
        drive(1'b1, 12'hFFF, 1'b0, '0);
        checks++;
        if (ack0 !== 1'b1) begin
            errors++;
            $display("FAIL boundary_ack ack0=%b expected 1", ack0);
        end
        idle(1);
        checks++;
        if (rom_add !== 12'hFFF) begin
            errors++;
            $display("FAIL boundary_rom_add rom_add=%h expected FFF", rom_add);
        end
        idle(5);
        checks++;
        if (ret_q.size() != 1 || rdata0 !== 8'h5A) begin
            errors++;
            $display("FAIL boundary_data count=%0d rdata0=%h expected 1 5A", ret_q.size(), rdata0);
        end
        checks++;
        if (both_seen != 0) begin
            errors++;
            $display("FAIL dual_rvalid seen=%0d expected 0", both_seen);
        end
        $display("test_boundary rom_add=%h rdata0=%h", rom_add, rdata0);
    endtask

    initial begin
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        addr0 = '0;
        addr1 = '0;
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_reset_midflight();
        test_fairness();
        test_boundary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
